// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the fetch front-end and the decoder:
//   INSTR_W              instruction word width
//   *_HI / *_LO          bit positions of the decoded fields
//   instr_fields_t       the field bundle handed to decode
//   fetch_state_t        fetch FSM encoding (exposed on the debug port)
//   get_fields()         slices an instruction word into instr_fields_t
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int INSTR_W  = 32;

   localparam int COND_HI  = 31;
   localparam int COND_LO  = 28;
   localparam int OP_HI    = 27;
   localparam int OP_LO    = 26;
   localparam int FUNCT_HI = 25;
   localparam int FUNCT_LO = 20;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 12;

   typedef struct packed {
      logic [COND_HI-COND_LO:0]   cond;
      logic [OP_HI-OP_LO:0]       op;
      logic [FUNCT_HI-FUNCT_LO:0] funct;
      logic [RD_HI-RD_LO:0]       rd;
   } instr_fields_t;

   // RUN: responses are kept. DRAIN: responses belonging to squashed
   // fetches are still in flight and get discarded.
   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } fetch_state_t;

   function automatic instr_fields_t get_fields(input logic [INSTR_W-1:0] instr);
      instr_fields_t f;
      f.cond  = instr[COND_HI:COND_LO];
      f.op    = instr[OP_HI:OP_LO];
      f.funct = instr[FUNCT_HI:FUNCT_LO];
      f.rd    = instr[RD_HI:RD_LO];
      return f;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch unit's memory request/response channel, the branch
// redirect input and the decode hand-off.
//   master : the fetch unit side
//   slave  : the environment side (instruction memory, execute, decode)
//
// Handshake semantics (imem_req_*, dec_*): a transfer happens on a rising clk
// edge where valid && ready are both high. ready may depend on valid, valid
// never depends on ready. While valid && !ready the payload holds stable.
// The only case where imem_req_valid drops without a transfer is a redirect,
// which discards the pending fetch on purpose.
// imem_rsp_valid and redirect_valid are single-cycle pulses with no ready.
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
   parameter int ADDR_W = 32
) ();

   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rsp_valid;
   logic [31:0]       imem_rsp_data;

   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;

   logic              dec_valid;
   logic              dec_ready;
   logic [31:0]       dec_instr;
   logic [3:0]        dec_cond;
   logic [1:0]        dec_op;
   logic [5:0]        dec_funct;
   logic [3:0]        dec_rd;
   logic [ADDR_W-1:0] dec_pc;

   modport master (
      output imem_req_valid, imem_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_addr,
      output dec_valid, dec_instr, dec_cond, dec_op, dec_funct, dec_rd, dec_pc,
      input  dec_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_addr,
      input  dec_valid, dec_instr, dec_cond, dec_op, dec_funct, dec_rd, dec_pc,
      output dec_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO with a flush input; used for the instruction buffer
// and the fetch-address tag queue.
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          empties the FIFO; wins over push and pop
//   push, wdata    write (ignored when full)
//   pop            advance head (ignored when empty)
//   rdata          head entry (meaningless while empty)
//   count          occupancy, 0..DEPTH
//   empty, full    status
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_q];
   assign count   = cnt_q;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + AW'(1);
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front-end: owns the PC, issues word reads to instruction
// memory, buffers returned words and hands them to decode split into fields.
// Branch redirects flush the buffer and squash in-flight fetches.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          fetch_unit_if.master (imem request/response, redirect, decode)
//   dbg_state    fetch FSM state (RUN / DRAIN)
// Optional build macro FETCH_PERF_CNT_EN adds:
//   stall_cnt    saturating count of cycles with dec_ready && !dec_valid
//   flush_cnt    saturating count of redirects
// Parameters: ADDR_W (PC width), RESET_PC (word aligned), DEPTH (power of 2, >=2)
// -----------------------------------------------------------------------------
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus,
   output fetch_state_t dbg_state
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  stall_cnt,
   output logic [15:0]  flush_cnt
`endif
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int CRW   = CW + 1;
   localparam int BUF_W = INSTR_W + ADDR_W;

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [CW-1:0]      outst_q, outst_d, drop_q, drop_d;
   logic               accept, rsp, redir, keep_rsp, dec_pop, buf_valid;
   logic [CRW-1:0]     credit_used;
   logic [BUF_W-1:0]   buf_wdata, buf_rdata;
   logic [CW-1:0]      buf_count, tag_count;
   logic               buf_empty, buf_full, tag_empty, tag_full;
   logic [ADDR_W-1:0]  tag_rdata;
   logic [INSTR_W-1:0] head_instr;
   logic [ADDR_W-1:0]  head_pc;
   instr_fields_t      fields;

   assign redir = bus.redirect_valid;
   assign rsp   = bus.imem_rsp_valid;

   // Buffered plus in-flight words may never exceed DEPTH, so every response
   // has a free buffer slot. Requests are held off during reset and in the
   // redirect cycle (the current PC is stale then).
   assign credit_used        = CRW'(buf_count) + CRW'(outst_q);
   assign bus.imem_req_valid = rst_n && !redir && (credit_used < CRW'(DEPTH));
   assign bus.imem_addr      = pc_q;
   assign accept             = bus.imem_req_valid && bus.imem_req_ready;

   // Responses to squashed fetches never had their tag kept, so they bypass
   // the tag queue as well as the buffer.
   assign keep_rsp  = rsp && (state_q == ST_RUN) && !redir;
   assign buf_valid = !buf_empty;
   assign dec_pop   = buf_valid && bus.dec_ready && !redir;
   assign buf_wdata = {bus.imem_rsp_data, tag_rdata};

   fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redir),
      .push  (accept),
      .wdata (pc_q),
      .pop   (keep_rsp),
      .rdata (tag_rdata),
      .count (tag_count),
      .empty (tag_empty),
      .full  (tag_full)
   );

   fetch_fifo #(.W(BUF_W), .DEPTH(DEPTH)) u_buf_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redir),
      .push  (keep_rsp),
      .wdata (buf_wdata),
      .pop   (dec_pop),
      .rdata (buf_rdata),
      .count (buf_count),
      .empty (buf_empty),
      .full  (buf_full)
   );

   // Head is forced to zero while empty so decode never sees stale storage.
   assign head_instr    = buf_valid ? buf_rdata[BUF_W-1:ADDR_W] : '0;
   assign head_pc       = buf_valid ? buf_rdata[ADDR_W-1:0]     : '0;
   assign fields        = get_fields(head_instr);
   assign bus.dec_valid = buf_valid;
   assign bus.dec_instr = head_instr;
   assign bus.dec_pc    = head_pc;
   assign bus.dec_cond  = fields.cond;
   assign bus.dec_op    = fields.op;
   assign bus.dec_funct = fields.funct;
   assign bus.dec_rd    = fields.rd;
   assign dbg_state     = state_q;

   always_comb begin
      outst_d = outst_q + CW'(accept) - CW'(rsp);
      pc_d    = pc_q;
      if (redir) begin
         pc_d = {bus.redirect_addr[ADDR_W-1:2], 2'b00};
      end else if (accept) begin
         pc_d = pc_q + ADDR_W'(4);
      end
   end

   // FSM: everything still in flight after a redirect belongs to the old
   // path, so the drop count is reloaded from the updated outstanding count.
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      if (redir) begin
         drop_d = outst_d;
      end else if (rsp && (state_q == ST_DRAIN)) begin
         drop_d = drop_q - CW'(1);
      end
      case (state_q)
         ST_RUN:   if (drop_d != '0) state_d = ST_DRAIN;
         ST_DRAIN: if (drop_d == '0) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (bus.dec_ready && !buf_valid && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (redir && (flush_q != '1))                      flush_d = flush_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`endif

   // Buffered + outstanding never exceeds DEPTH, so a response never meets a full buffer.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(keep_rsp && buf_full));
   // Every in-flight fetch is either tagged or scheduled to be dropped.
   a_tag_track: assert property (@(posedge clk) disable iff (!rst_n)
      (CRW'(tag_count) + CRW'(drop_q)) == CRW'(outst_q));
   a_tag_room: assert property (@(posedge clk) disable iff (!rst_n) !(accept && tag_full));
   a_tag_avail: assert property (@(posedge clk) disable iff (!rst_n) !(keep_rsp && tag_empty));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import cpu_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial rst_n = 1'b0;

   fetch_unit_if #(.ADDR_W(32)) bus ();
   fetch_state_t dbg_state;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'hE0810002 : (32'hA5000000 ^ a);
   endfunction

   // ---------------- instruction memory model ----------------
   // Accepted addresses answer lat cycles later, in order, one per cycle.
   int lat = 1;
   int cyc = 0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];

   initial begin
      logic        acc;
      logic [31:0] a;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         acc = rst_n && bus.imem_req_valid && bus.imem_req_ready;
         a   = bus.imem_addr;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            bus.imem_rsp_valid = 1'b0;
         end else begin
            cyc++;
            if (acc) begin
               pend_addr.push_back(a);
               pend_due.push_back(cyc + lat - 1);
            end
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
               bus.imem_rsp_valid = 1'b1;
               bus.imem_rsp_data  = mem_word(pend_addr[0]);
               void'(pend_addr.pop_front());
               void'(pend_due.pop_front());
            end else begin
               bus.imem_rsp_valid = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Leaves the bench 3 time units into cycle 0 after release.
   task automatic do_reset(input logic rdy);
      @(posedge clk);
      #2;
      rst_n              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = '0;
      bus.dec_ready      = rdy;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic redirect(input logic [31:0] target);
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = target;
      #1;
      check("redir_req_suppressed", 32'(bus.imem_req_valid), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
   endtask

   // Consume with dec_ready high until every expected pc has been seen.
   task automatic consume(input int budget);
      logic [31:0] e;
      int n = 0;
      bus.dec_ready = 1'b1;
      while (exp_q.size() > 0 && n < budget) begin
         if (bus.dec_valid) begin
            e = exp_q.pop_front();
            check("dec_pc", bus.dec_pc, e);
            check("dec_instr", bus.dec_instr, mem_word(e));
         end
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         check("consume_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = '0;
      bus.dec_ready      = 1'b0;

      // T1: first fetch latency, field split, then in-order stream
      lat = 1;
      do_reset(1'b1);
      check("c0_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("c0_addr", bus.imem_addr, 32'h0);
      check("c0_dec_valid", 32'(bus.dec_valid), 32'd0);
      check("c0_dec_instr", bus.dec_instr, 32'h0);
      check("c0_dec_pc", bus.dec_pc, 32'h0);
      check("c0_state", 32'(dbg_state), 32'(ST_RUN));
      tick();
      check("c1_dec_valid", 32'(bus.dec_valid), 32'd0);
      check("c1_addr", bus.imem_addr, 32'h4);
      tick();
      check("c2_dec_valid", 32'(bus.dec_valid), 32'd1);
      check("c2_instr", bus.dec_instr, 32'hE0810002);
      check("c2_cond", 32'(bus.dec_cond), 32'hE);
      check("c2_op", 32'(bus.dec_op), 32'h0);
      check("c2_funct", 32'(bus.dec_funct), 32'h08);
      check("c2_rd", 32'(bus.dec_rd), 32'h0);
      check("c2_pc", bus.dec_pc, 32'h0);
      check("c2_credit_full", 32'(bus.imem_req_valid), 32'd0);
      tick();
      exp_q = '{32'h4, 32'h8, 32'hC};
      consume(12);

      // T2: decode stalled 5 cycles; credits cap fetches, head holds
      lat = 1;
      do_reset(1'b0);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("hold%0d_req", i), 32'(bus.imem_req_valid), 32'd0);
         check($sformatf("hold%0d_valid", i), 32'(bus.dec_valid), 32'd1);
         check($sformatf("hold%0d_pc", i), bus.dec_pc, 32'h0);
         check($sformatf("hold%0d_instr", i), bus.dec_instr, 32'hE0810002);
         tick();
      end
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      consume(20);

      // T3: redirect with two fetches in flight
      lat = 3;
      do_reset(1'b1);
      tick();
      tick();
      redirect(32'h100);
      check("t3_state", 32'(dbg_state), 32'(ST_DRAIN));
      check("t3_addr", bus.imem_addr, 32'h100);
      check("t3_dec_valid", 32'(bus.dec_valid), 32'd0);
      exp_q = '{32'h100, 32'h104, 32'h108};
      consume(40);

      // T4: unaligned target, then second redirect while draining
      lat = 3;
      do_reset(1'b1);
      tick();
      redirect(32'h103);
      check("t4_addr_aligned", bus.imem_addr, 32'h100);
      check("t4_req_in_drain", 32'(bus.imem_req_valid), 32'd1);
      check("t4_state", 32'(dbg_state), 32'(ST_DRAIN));
      tick();
      check("t4_state_pre2", 32'(dbg_state), 32'(ST_DRAIN));
      redirect(32'h200);
      exp_q = '{32'h200, 32'h204};
      consume(40);

      // T5: PC wraps past the top of the address space
      lat = 1;
      do_reset(1'b1);
      redirect(32'hFFFFFFFF);
      check("t5_addr_top", bus.imem_addr, 32'hFFFFFFFC);
      check("t5_req", 32'(bus.imem_req_valid), 32'd1);
      check("t5_state", 32'(dbg_state), 32'(ST_RUN));
      tick();
      check("t5_addr_wrap", bus.imem_addr, 32'h0);
      exp_q = '{32'hFFFFFFFC, 32'h0, 32'h4};
      consume(20);

      // T6: asynchronous reset mid-stream with responses pending
      lat = 3;
      do_reset(1'b0);
      repeat (4) tick();
      check("t6_pre_valid", 32'(bus.dec_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      lat   = 1;
      #1;
      check("t6_rst_dec_valid", 32'(bus.dec_valid), 32'd0);
      check("t6_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("t6_rst_instr", bus.dec_instr, 32'h0);
      check("t6_rst_pc", bus.dec_pc, 32'h0);
      check("t6_rst_state", 32'(dbg_state), 32'(ST_RUN));
      repeat (2) @(posedge clk);
      #2;
      rst_n         = 1'b1;
      bus.dec_ready = 1'b1;
      #1;
      check("t6_rel_addr", bus.imem_addr, 32'h0);
      check("t6_rel_valid", 32'(bus.dec_valid), 32'd0);
      check("t6_rel_req", 32'(bus.imem_req_valid), 32'd1);
      tick();
      tick();
      check("t6_c2_valid", 32'(bus.dec_valid), 32'd1);
      check("t6_c2_pc", bus.dec_pc, 32'h0);
      tick();
      exp_q = '{32'h4, 32'h8};
      consume(12);

      // ---------------- final report ----------------
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
